// File: rtl/fpadd_pipe.sv
// fpadd_pipe: 4-stage pipelined IEEE-style adder/subtractor, round-to-nearest-even, global stall.
// Define FPADD_SUBNORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fpadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic         ovf
);
  localparam int M = MAN_W + 1;
  localparam int X = MAN_W + 4;
  localparam int L = MAN_W + 5;
  localparam int LZW = $clog2(L + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;

  function automatic logic [LZW-1:0] lzc(input logic [L-1:0] v);
    lzc = LZW'(L);
    for (int i = 0; i < L; i++) if (v[i]) lzc = LZW'(L - 1 - i);
  endfunction

  logic en;
  assign en = out_ready || !out_valid;
  assign in_ready = en;

  logic               v1_q, nan1_q, inf1_q, sgn1_q, sub1_q;
  logic               nan1_d, inf1_d, sgn1_d, sub1_d;
  logic [EXP_W-1:0]   e1_q, d1_q, e1_d, d1_d;
  logic [M-1:0]       mb1_q, ms1_q, mb1_d, ms1_d;
  logic               v2_q, nan2_q, inf2_q, sgn2_q, sub2_q;
  logic [EXP_W-1:0]   e2_q;
  logic [X-1:0]       bx2_q, sx2_q, bx2_d, sx2_d;
  logic               v3_q, nan3_q, inf3_q, sgn3_q, sub3_q;
  logic [EXP_W-1:0]   e3_q;
  logic [L-1:0]       sum3_q, sum3_d;
  logic [LZW-1:0]     lz3_q, lz3_d;
  logic [W-1:0]       out_d;
  logic               ovf_d;

  logic               sa, sb, nan_a, nan_b, inf_a, inf_b, a_big;
  logic [EXP_W-1:0]   xa, xb, ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic [M-1:0]       ma, mb;
  always_comb begin
    sa = src1[W-1];
    sb = src2[W-1] ^ sub;
    xa = src1[W-2:MAN_W];
    xb = src2[W-2:MAN_W];
    fa = src1[MAN_W-1:0];
    fb = src2[MAN_W-1:0];
    nan_a = (xa == EMAX) && |fa;
    nan_b = (xb == EMAX) && |fb;
    inf_a = (xa == EMAX) && !(|fa);
    inf_b = (xb == EMAX) && !(|fb);
`ifdef FPADD_SUBNORM_EN
    ea = |xa ? xa : EXP_W'(1);
    eb = |xb ? xb : EXP_W'(1);
    ma = {|xa, fa};
    mb = {|xb, fb};
`else
    ea = xa;
    eb = xb;
    ma = |xa ? {1'b1, fa} : '0;
    mb = |xb ? {1'b1, fb} : '0;
`endif
    a_big = {ea, ma} >= {eb, mb};
    nan1_d = nan_a || nan_b || (inf_a && inf_b && (sa ^ sb));
    inf1_d = inf_a || inf_b;
    sgn1_d = a_big ? sa : sb;
    sub1_d = sa ^ sb;
    e1_d = a_big ? ea : eb;
    d1_d = a_big ? ea - eb : eb - ea;
    mb1_d = a_big ? ma : mb;
    ms1_d = a_big ? mb : ma;
  end

  // Shift amount saturates once every mantissa bit has fallen into sticky.
  logic [31:0]        sh2;
  logic [2*M+3:0]     al2;
  always_comb begin
    sh2 = (32'(d1_q) > 32'(M + 2)) ? 32'(M + 2) : 32'(d1_q);
    al2 = {ms1_q, 2'b00, {(M + 2){1'b0}}} >> sh2;
    sx2_d = {al2[2*M+3 -: M+2], |al2[M+1:0]};
    bx2_d = {mb1_q, 3'b000};
  end

  always_comb begin
    sum3_d = sub2_q ? {1'b0, bx2_q} - {1'b0, sx2_q} : {1'b0, bx2_q} + {1'b0, sx2_q};
    lz3_d = lzc(sum3_d);
  end

  // Normalising shift is capped by the exponent so tiny results land on the subnormal grid.
  logic [31:0]        sh4;
  logic [L-1:0]       nrm4;
  logic [EXP_W:0]     ex4, ef4;
  logic [M:0]         mr4;
  logic               rnd4, big4;
  logic [MAN_W-1:0]   frac4;
  always_comb begin
    sh4 = (32'(lz3_q) > 32'(e3_q)) ? 32'(e3_q) : 32'(lz3_q);
    nrm4 = sum3_q << sh4;
    ex4 = (EXP_W+1)'(e3_q) + (EXP_W+1)'(1) - (EXP_W+1)'(sh4);
    rnd4 = nrm4[3] && (|nrm4[2:0] || nrm4[4]);
    mr4 = {1'b0, nrm4[L-1:4]} + (M+1)'(rnd4);
    ef4 = mr4[M] ? ex4 + (EXP_W+1)'(1) : (mr4[M-1] ? ex4 : '0);
    big4 = ef4 >= {1'b0, EMAX};
`ifdef FPADD_SUBNORM_EN
    frac4 = mr4[MAN_W-1:0];
`else
    frac4 = |ef4 ? mr4[MAN_W-1:0] : '0;
`endif
    out_d = nan3_q ? {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}}
          : inf3_q ? {sgn3_q, EMAX, {MAN_W{1'b0}}}
          : !(|sum3_q) ? {sgn3_q && !sub3_q, {(W-1){1'b0}}}
          : big4 ? {sgn3_q, EMAX, {MAN_W{1'b0}}}
          : {sgn3_q, ef4[EXP_W-1:0], frac4};
    ovf_d = !nan3_q && !inf3_q && |sum3_q && big4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      nan1_q <= 1'b0;
      inf1_q <= 1'b0;
      sgn1_q <= 1'b0;
      sub1_q <= 1'b0;
      e1_q <= '0;
      d1_q <= '0;
      mb1_q <= '0;
      ms1_q <= '0;
      v2_q <= 1'b0;
      nan2_q <= 1'b0;
      inf2_q <= 1'b0;
      sgn2_q <= 1'b0;
      sub2_q <= 1'b0;
      e2_q <= '0;
      bx2_q <= '0;
      sx2_q <= '0;
      v3_q <= 1'b0;
      nan3_q <= 1'b0;
      inf3_q <= 1'b0;
      sgn3_q <= 1'b0;
      sub3_q <= 1'b0;
      e3_q <= '0;
      sum3_q <= '0;
      lz3_q <= '0;
      out_valid <= 1'b0;
      out <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      nan1_q <= nan1_d;
      inf1_q <= inf1_d;
      sgn1_q <= sgn1_d;
      sub1_q <= sub1_d;
      e1_q <= e1_d;
      d1_q <= d1_d;
      mb1_q <= mb1_d;
      ms1_q <= ms1_d;
      v2_q <= v1_q;
      nan2_q <= nan1_q;
      inf2_q <= inf1_q;
      sgn2_q <= sgn1_q;
      sub2_q <= sub1_q;
      e2_q <= e1_q;
      bx2_q <= bx2_d;
      sx2_q <= sx2_d;
      v3_q <= v2_q;
      nan3_q <= nan2_q;
      inf3_q <= inf2_q;
      sgn3_q <= sgn2_q;
      sub3_q <= sub2_q;
      e3_q <= e2_q;
      sum3_q <= sum3_d;
      lz3_q <= lz3_d;
      out_valid <= v3_q;
      out <= out_d;
      ovf <= ovf_d;
    end
  end
endmodule
